ps2_kbd_rx_fifo: RTL and testbench
==================================

Name: ps2_kbd_rx_fifo

Overview:
Parametrised next-generation PS/2 keyboard receiver. It deframes PS/2 bytes and decodes E0 (extended) and F0 (break) prefixes into key events. It flags typematic repeats, tracks held-key state and a make counter, and buffers events in a FIFO with a valid/ready output. It feeds scan-code-to-ASCII and display logic.

Parameters:
FIFO_DEPTH, 8, event FIFO entries; power of two, at least 2.
COUNT_W, 8, width of the make-event counter.
TIMEOUT_CYC, 50000, clk cycles without a PS/2 falling edge before a partial frame is abandoned.

Ports:
clk  input  1  system clock; the only clock.
rst  input  1  reset; synchronous, active-high.
ps2_clk  input  1  raw PS/2 clock, asynchronous.
ps2_data  input  1  raw PS/2 data, asynchronous.
evt_code  output  8  scan code at FIFO head.
evt_ext  output  1  head event carried E0 prefix.
evt_brk  output  1  head event is a release (F0 prefix).
evt_rep  output  1  head event is a typematic repeat.
evt_valid  output  1  FIFO non-empty.
evt_ready  input  1  consumer pop; takes effect when evt_valid is 1.
count  output  COUNT_W  number of non-repeat make events.
is_press  output  1  a key is currently held.
frame_err  output  1  one-cycle pulse on each discarded frame.
overflow  output  1  sticky: an event was dropped because the FIFO was full.
fifo_level  output  $clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge) clears all registers. All outputs read 0, including evt_code, fifo_level and overflow. Reset mid-frame discards the partial frame, the prefix state and held-key state.
- Sync: ps2_clk and ps2_data each pass a 2-FF synchronizer. A third ps2_clk stage detects falling edges. Data is sampled on the detected falling-edge cycle.
- Frame: 11 bits. Start=0, 8 data bits LSB first, odd parity, stop=1.
  - A wrong start, parity or stop bit discards the byte and pulses frame_err for 1 cycle.
  - The bit counter returns to 0 after every 11th bit, good or bad.
- Timeout: when the bit counter is non-zero and no falling edge arrives for TIMEOUT_CYC cycles, the counter clears and frame_err pulses once. An idle bus (counter 0) never times out.
- Decoder FSM, stepped once per good byte:
  - States: IDLE, EXT, BRK, EXT_BRK.
  - From IDLE: E0 goes to EXT; F0 goes to BRK.
  - From EXT: F0 goes to EXT_BRK.
  - Any other byte emits an event {ext,brk,code} per the current state, then returns to IDLE.
  - In EXT: E0 stays in EXT.
  - In BRK or EXT_BRK: E0 or F0 is treated as a code and emits an event.
- Held key: register {held_ext, held_code, held_valid}.
  - Make event matching the held key while held_valid=1: rep=1; count is unchanged.
  - Make event not matching: rep=0, held key is replaced, count increments. Count wraps modulo 2^COUNT_W.
  - Break event matching the held key: held_valid clears. A break for any other key leaves held state unchanged.
  - is_press = held_valid.
- Latency: stop bit sampled at cycle T. Decode and FIFO write happen at T+1. evt_valid and head outputs reflect the event at T+2. count and is_press update at T+2.
- FIFO: first-word-fall-through with registered head. Word width is 11 bits {rep,ext,brk,code}.
  - Pop when evt_valid & evt_ready.
  - Push when full is dropped and sets overflow, unless a pop occurs in the same cycle; then the push is accepted and level stays at FIFO_DEPTH.
  - Push and pop on non-empty, non-full: level unchanged.
  - Pop when empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- With evt_valid=0 the head outputs hold their last value; 0 after reset.
- overflow clears only on rst.

Test Plan:
- Frame 0x1C, evt_ready=0 -> evt_valid=1, head {rep0,ext0,brk0,0x1C}, count=1, is_press=1, fifo_level=1.
- Frames F0,1C, then pop all -> second event {0,0,1,0x1C}, is_press=0, count=1. No event is emitted for F0.
- Frames E0,75 then E0,F0,75 -> events {0,1,0,0x75} then {0,1,1,0x75}, count=1.
- Frames 1C,1C,1C -> three events with rep=0,1,1, count=1.
- FIFO_DEPTH=4, evt_ready=0, six make codes -> level=4, overflow=1, head is the first code. Popping 4 returns the first four codes in order.
- Bad parity on 0x1C -> frame_err 1-cycle pulse, no event. Next, 5 bits then idle TIMEOUT_CYC cycles -> frame_err pulse. A following good 0x32 frame -> event 0x32.

Source files
------------

// File: rtl/ps2_kbd_rx_fifo.sv
// ps2_kbd_rx_fifo: PS/2 keyboard receiver with E0/F0 prefix decoding,
// typematic-repeat flagging, held-key tracking and an event FIFO.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   ps2_clk, ps2_data   raw asynchronous PS/2 lines
//   evt_code/ext/brk/rep head-of-FIFO event fields (hold when empty)
//   evt_valid           FIFO non-empty
//   evt_ready           consumer pop, honoured while evt_valid=1
//   count               number of non-repeat make events (wraps)
//   is_press            a key is currently held
//   frame_err           one-cycle pulse per discarded or timed-out frame
//   overflow            sticky, an event was dropped on a full FIFO
//   fifo_level          current FIFO occupancy
module ps2_kbd_rx_fifo #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned COUNT_W     = 8,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  output logic [7:0]                    evt_code,
  output logic                          evt_ext,
  output logic                          evt_brk,
  output logic                          evt_rep,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [COUNT_W-1:0]            count,
  output logic                          is_press,
  output logic                          frame_err,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  typedef struct packed {
    logic       rep;
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } evt_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } state_t;

  // ---------------------------------------------------------------------
  // Input synchronizers; the third clock stage gives a falling-edge strobe
  // aligned with the second data stage.
  logic [2:0] pclk_q;
  logic [1:0] pdat_q;
  logic       fall_c;
  logic       din_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      pclk_q <= '0;
      pdat_q <= '0;
    end else begin
      pclk_q <= {pclk_q[1:0], ps2_clk};
      pdat_q <= {pdat_q[0], ps2_data};
    end
  end

  assign fall_c = pclk_q[2] & ~pclk_q[1];
  assign din_c  = pdat_q[1];

  // ---------------------------------------------------------------------
  // Deframer: shift start/data/parity in from the top so that after ten
  // bits sreg holds {parity, data[7:0], start}; the stop bit is checked live.
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [9:0]    sreg_q, sreg_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [7:0]    byte_q, byte_d;
  logic          byte_vld_q, byte_vld_d;
  logic          ferr_q, ferr_d;

  always_comb begin
    bitcnt_d   = bitcnt_q;
    sreg_d     = sreg_q;
    tcnt_d     = tcnt_q;
    byte_d     = byte_q;
    byte_vld_d = 1'b0;
    ferr_d     = 1'b0;
    if (fall_c) begin
      tcnt_d = '0;
      if (bitcnt_q == 4'd10) begin
        bitcnt_d = '0;
        if (!sreg_q[0] && din_c && (^sreg_q[9:1])) begin
          byte_d     = sreg_q[8:1];
          byte_vld_d = 1'b1;
        end else begin
          ferr_d = 1'b1;
        end
      end else begin
        sreg_d   = {din_c, sreg_q[9:1]};
        bitcnt_d = bitcnt_q + 4'd1;
      end
    end else if (bitcnt_q != 4'd0) begin
      // Abandon a partial frame after a long gap between edges.
      if (tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
        bitcnt_d = '0;
        tcnt_d   = '0;
        ferr_d   = 1'b1;
      end else begin
        tcnt_d = tcnt_q + TW'(1);
      end
    end else begin
      tcnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bitcnt_q   <= '0;
      sreg_q     <= '0;
      tcnt_q     <= '0;
      byte_q     <= '0;
      byte_vld_q <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      bitcnt_q   <= bitcnt_d;
      sreg_q     <= sreg_d;
      tcnt_q     <= tcnt_d;
      byte_q     <= byte_d;
      byte_vld_q <= byte_vld_d;
      ferr_q     <= ferr_d;
    end
  end

  // ---------------------------------------------------------------------
  // Prefix decoder and held-key tracker, stepped once per good byte.
  state_t             state_q, state_d;
  logic               held_vld_q, held_vld_d;
  logic               held_ext_q, held_ext_d;
  logic [7:0]         held_code_q, held_code_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               emit_c;
  logic               e_ext_c;
  logic               e_brk_c;
  logic               e_rep_c;
  logic               held_match_c;

  always_comb begin
    state_d = state_q;
    emit_c  = 1'b0;
    e_ext_c = 1'b0;
    e_brk_c = 1'b0;
    if (byte_vld_q) begin
      case (state_q)
        ST_IDLE: begin
          if (byte_q == 8'hE0)      state_d = ST_EXT;
          else if (byte_q == 8'hF0) state_d = ST_BRK;
          else                      emit_c  = 1'b1;
        end
        ST_EXT: begin
          if (byte_q == 8'hF0) begin
            state_d = ST_EXT_BRK;
          end else if (byte_q != 8'hE0) begin
            emit_c  = 1'b1;
            e_ext_c = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_BRK: begin
          emit_c  = 1'b1;
          e_brk_c = 1'b1;
          state_d = ST_IDLE;
        end
        ST_EXT_BRK: begin
          emit_c  = 1'b1;
          e_ext_c = 1'b1;
          e_brk_c = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign held_match_c = held_vld_q && (held_ext_q == e_ext_c) && (held_code_q == byte_q);

  always_comb begin
    held_vld_d  = held_vld_q;
    held_ext_d  = held_ext_q;
    held_code_d = held_code_q;
    count_d     = count_q;
    e_rep_c     = 1'b0;
    if (emit_c) begin
      if (!e_brk_c) begin
        if (held_match_c) begin
          e_rep_c = 1'b1;
        end else begin
          held_vld_d  = 1'b1;
          held_ext_d  = e_ext_c;
          held_code_d = byte_q;
          count_d     = count_q + COUNT_W'(1);
        end
      end else if (held_match_c) begin
        held_vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      held_vld_q  <= 1'b0;
      held_ext_q  <= 1'b0;
      held_code_q <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      held_vld_q  <= held_vld_d;
      held_ext_q  <= held_ext_d;
      held_code_q <= held_code_d;
      count_q     <= count_d;
    end
  end

  // ---------------------------------------------------------------------
  // Event FIFO with a registered head word.
  evt_t          mem_q [FIFO_DEPTH];
  evt_t          head_q, head_d;
  evt_t          push_word_c;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] level_q, level_d;
  logic          valid_q, valid_d;
  logic          ovf_q, ovf_d;
  logic          full_c, pop_c, push_ok_c;

  assign push_word_c = '{rep: e_rep_c, ext: e_ext_c, brk: e_brk_c, code: byte_q};
  assign full_c      = (level_q == LW'(FIFO_DEPTH));
  assign pop_c       = valid_q & evt_ready;
  // A full FIFO still accepts a push when the same cycle frees a slot.
  assign push_ok_c   = emit_c & (~full_c | pop_c);

  always_comb begin
    wr_d    = wr_q + PW'(push_ok_c);
    rd_d    = rd_q + PW'(pop_c);
    level_d = level_q + LW'(push_ok_c) - LW'(pop_c);
    valid_d = (level_d != '0);
    ovf_d   = ovf_q | (emit_c & full_c & ~pop_c);
    head_d  = head_q;
    if (level_d != '0) begin
      // The word landing at the new read pointer may be written this cycle.
      if (push_ok_c && (rd_d == wr_q)) head_d = push_word_c;
      else                             head_d = mem_q[rd_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      head_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (push_ok_c) mem_q[wr_q] <= push_word_c;
      head_q  <= head_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign evt_code   = head_q.code;
  assign evt_ext    = head_q.ext;
  assign evt_brk    = head_q.brk;
  assign evt_rep    = head_q.rep;
  assign evt_valid  = valid_q;
  assign count      = count_q;
  assign is_press   = held_vld_q;
  assign frame_err  = ferr_q;
  assign overflow   = ovf_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_ps2_kbd_rx_fifo.sv
// Testbench for ps2_kbd_rx_fifo: drives PS/2 frames, pushes expected events
// into a scoreboard queue and compares them as the FIFO is drained.
module tb_ps2_kbd_rx_fifo;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 8;
  localparam int unsigned TO    = 200;
  localparam int unsigned HALF  = 10;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      ps2_clk;
  logic                      ps2_data;
  logic                      evt_ready;
  logic [7:0]                evt_code;
  logic                      evt_ext, evt_brk, evt_rep, evt_valid;
  logic [CW-1:0]             count;
  logic                      is_press, frame_err, overflow;
  logic [$clog2(DEPTH):0]    fifo_level;

  ps2_kbd_rx_fifo #(.FIFO_DEPTH(DEPTH), .COUNT_W(CW), .TIMEOUT_CYC(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .evt_code   (evt_code),
    .evt_ext    (evt_ext),
    .evt_brk    (evt_brk),
    .evt_rep    (evt_rep),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .count      (count),
    .is_press   (is_press),
    .frame_err  (frame_err),
    .overflow   (overflow),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_bad = 0;
  logic [10:0] exp_q [$];
  int          fe_rise = 0;
  int          fe_hi   = 0;
  logic        fe_prev = 1'b0;

  // frame_err pulse monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (frame_err) fe_hi++;
    if (frame_err && !fe_prev) fe_rise++;
    fe_prev = frame_err;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    wait_clk(HALF / 2);
    ps2_clk = 1'b0;
    wait_clk(HALF);
    ps2_clk = 1'b1;
    wait_clk(HALF / 2);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(bad_par ? (^b) : ~(^b));
    send_bit(1'b1);
    wait_clk(8);
  endtask

  // push expected {rep,ext,brk,code}
  task automatic expect_evt(input logic rep, input logic ext, input logic brk, input logic [7:0] code);
    exp_q.push_back({rep, ext, brk, code});
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) begin
      int t;
      logic [10:0] e;
      t = 0;
      while (!evt_valid && t < 2000) begin
        wait_clk(1);
        t++;
      end
      if (!evt_valid) begin
        chk("pop_wait", 32'(evt_valid), 32'd1);
        return;
      end
      if (exp_q.size() == 0) begin
        chk("sb_empty", 32'(exp_q.size()), 32'd1);
        e = '0;
      end else begin
        e = exp_q.pop_front();
      end
      chk("evt", 32'({evt_rep, evt_ext, evt_brk, evt_code}), 32'(e));
      evt_ready = 1'b1;
      wait_clk(1);
      evt_ready = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wait_clk(2);
    rst = 1'b0;
    exp_q.delete();
    wait_clk(2);
  endtask

  initial begin
    int fr0, fh0;
    rst       = 1'b1;
    ps2_clk   = 1'b1;
    ps2_data  = 1'b1;
    evt_ready = 1'b0;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(2);

    // reset state
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_head", 32'({evt_rep, evt_ext, evt_brk, evt_code}), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_press", 32'(is_press), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);

    // single make, not popped
    send_frame(8'h1C, 1'b0);
    expect_evt(1'b0, 1'b0, 1'b0, 8'h1C);
    chk("mk_valid", 32'(evt_valid), 32'd1);
    chk("mk_head", 32'({evt_rep, evt_ext, evt_brk, evt_code}), 32'h01C);
    chk("mk_count", 32'(count), 32'd1);
    chk("mk_press", 32'(is_press), 32'd1);
    chk("mk_level", 32'(fifo_level), 32'd1);

    // break: F0 itself emits nothing
    send_frame(8'hF0, 1'b0);
    chk("f0_level", 32'(fifo_level), 32'd1);
    send_frame(8'h1C, 1'b0);
    expect_evt(1'b0, 1'b0, 1'b1, 8'h1C);
    chk("brk_level", 32'(fifo_level), 32'd2);
    drain(2);
    chk("brk_press", 32'(is_press), 32'd0);
    chk("brk_count", 32'(count), 32'd1);
    chk("brk_empty", 32'(fifo_level), 32'd0);

    // extended make and extended break
    do_reset();
    send_frame(8'hE0, 1'b0);
    send_frame(8'h75, 1'b0);
    expect_evt(1'b0, 1'b1, 1'b0, 8'h75);
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    expect_evt(1'b0, 1'b1, 1'b1, 8'h75);
    drain(2);
    chk("ext_count", 32'(count), 32'd1);
    chk("ext_press", 32'(is_press), 32'd0);

    // typematic repeat
    do_reset();
    for (int i = 0; i < 3; i++) send_frame(8'h1C, 1'b0);
    expect_evt(1'b0, 1'b0, 1'b0, 8'h1C);
    expect_evt(1'b1, 1'b0, 1'b0, 8'h1C);
    expect_evt(1'b1, 1'b0, 1'b0, 8'h1C);
    drain(3);
    chk("rep_count", 32'(count), 32'd1);
    chk("rep_press", 32'(is_press), 32'd1);

    // overflow on a depth-4 FIFO
    do_reset();
    begin
      logic [7:0] codes [6];
      codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35};
      for (int i = 0; i < 6; i++) send_frame(codes[i], 1'b0);
      for (int i = 0; i < 4; i++) expect_evt(1'b0, 1'b0, 1'b0, codes[i]);
    end
    chk("ovf_level", 32'(fifo_level), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_head", 32'(evt_code), 32'h15);
    drain(4);
    chk("ovf_empty", 32'(fifo_level), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd6);

    // reset mid-frame, bad parity, timeout, then recovery
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    do_reset();
    fr0 = fe_rise;
    fh0 = fe_hi;
    send_frame(8'h1C, 1'b0);
    expect_evt(1'b0, 1'b0, 1'b0, 8'h1C);
    drain(1);
    chk("midrst_noerr", 32'(fe_rise - fr0), 32'd0);
    send_frame(8'h1C, 1'b1);
    chk("par_pulse", 32'(fe_rise - fr0), 32'd1);
    chk("par_width", 32'(fe_hi - fh0), 32'd1);
    chk("par_noevt", 32'(fifo_level), 32'd0);
    for (int i = 0; i < 5; i++) send_bit(1'(i % 2));
    wait_clk(TO + 50);
    chk("to_pulse", 32'(fe_rise - fr0), 32'd2);
    chk("to_width", 32'(fe_hi - fh0), 32'd2);
    wait_clk(TO + 50);
    chk("idle_no_to", 32'(fe_rise - fr0), 32'd2);
    send_frame(8'h32, 1'b0);
    expect_evt(1'b0, 1'b0, 1'b0, 8'h32);
    drain(1);
    chk("hold_code", 32'(evt_code), 32'h32);
    chk("hold_valid", 32'(evt_valid), 32'd0);

    // pop while empty is ignored
    evt_ready = 1'b1;
    wait_clk(3);
    evt_ready = 1'b0;
    chk("empty_pop", 32'(fifo_level), 32'd0);
    chk("sb_left", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
